// File: rtl/riscstrong_ctrl_pkg.sv
// Shared definitions for the RiscStrong multi-cycle controller.
// Holds the 4-bit state encoding, the opcode[6:2] class constants, the
// decoded instruction classes and the datapath select encodings that the
// controller drives onto the shared-memory datapath.
package riscstrong_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_EXEC_U   = 4'd4,
    ST_BRANCH   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_WB_ALU   = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_JAL      = 4'd11,
    ST_JALR     = 4'd12,
    ST_TRAP     = 4'd13
  } state_t;

  // opcode[6:2] values for each instruction class
  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_I      = 5'b00100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_U      = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_MEM    = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_JALR   = 3'd6,
    CLS_NONE   = 3'd7
  } opclass_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier for the RiscStrong controller.
// Ports:
//   i_opcode  - IR[6:0]
//   o_class   - decoded instruction class (CLS_NONE when undecodable)
//   o_illegal - high when the opcode cannot be executed
// Jump and upper-immediate classes are only recognised when the matching
// parameter is non-zero; otherwise they fall through to CLS_NONE.
module opcode_class_decode
  import riscstrong_ctrl_pkg::*;
#(
  parameter int HAS_JUMP  = 1,
  parameter int HAS_UPPER = 1
) (
  input  logic [6:0] i_opcode,
  output opclass_t   o_class,
  output logic       o_illegal
);

  // Classify on opcode[6:2]; every 32-bit instruction must also carry 11
  // in the low two bits, anything else is treated as undecodable.
  always_comb begin
    o_class = CLS_NONE;
    case (i_opcode[6:2])
      OPC_R:                o_class = CLS_R;
      OPC_I:                o_class = CLS_I;
      OPC_LUI, OPC_AUIPC:   if (HAS_UPPER != 0) o_class = CLS_U;
      OPC_BRANCH:           o_class = CLS_BRANCH;
      OPC_LOAD, OPC_STORE:  o_class = CLS_MEM;
      OPC_JAL:              if (HAS_JUMP != 0) o_class = CLS_JAL;
      OPC_JALR:             if (HAS_JUMP != 0) o_class = CLS_JALR;
      default:              o_class = CLS_NONE;
    endcase
    if (i_opcode[1:0] != 2'b11) o_class = CLS_NONE;
    o_illegal = (o_class == CLS_NONE);
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle main controller for the RiscStrong core.
// Sequences each instruction through fetch/decode/execute/memory/write-back
// and drives the shared-memory datapath controls.
// Ports:
//   i_clk, i_rst         - clock, synchronous active-high reset
//   i_opcode             - IR[6:0], valid from DECODE onward
//   i_mem_ready          - memory completes the current request this cycle
//   o_mem_req/o_mem_we   - memory request / write qualifier
//   o_i_or_d             - address select (0 PC, 1 ALUOut)
//   o_ir_write/o_pc_write/o_branch - IR load, PC load, conditional PC load
//   o_alu_op/o_alu_src_a/o_alu_src_b - ALU controls
//   o_reg_write/o_mem_to_reg - register-file write and write-back select
//   o_retire/o_instret   - completion pulse and retired-instruction count
//   o_illegal/o_bus_err  - sticky trap causes
module mc_control_unit
  import riscstrong_ctrl_pkg::*;
#(
  parameter int HAS_JUMP   = 1,
  parameter int HAS_UPPER  = 1,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_i_or_d,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_branch,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic             o_reg_write,
  output logic [1:0]       o_mem_to_reg,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_instret,
  output logic             o_illegal,
  output logic             o_bus_err
);

  localparam int WCW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t           r_state;
  state_t           w_nextState;
  logic [WCW-1:0]   r_waitCnt;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;
  logic             r_busErr;

  opclass_t w_class;
  logic     w_decIllegal;
  logic     w_inReq;
  logic     w_timeout;
  logic     w_setIllegal;
  logic     w_setBusErr;

  logic       w_memReq, w_memWe, w_iOrD, w_irWrite, w_pcWrite, w_branch;
  logic       w_regWrite, w_retire;
  logic [1:0] w_aluOp, w_srcA, w_srcB, w_memToReg;

  opcode_class_decode #(
    .HAS_JUMP  (HAS_JUMP),
    .HAS_UPPER (HAS_UPPER)
  ) u_decode (
    .i_opcode  (i_opcode),
    .o_class   (w_class),
    .o_illegal (w_decIllegal)
  );

  // The stall budget is spent when this cycle would be the WAIT_LIMIT-th
  // cycle without ready; a ready on that same cycle still completes.
  assign w_inReq   = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                     (r_state == ST_MEM_WR);
  assign w_timeout = (WAIT_LIMIT > 0) && w_inReq && !i_mem_ready &&
                     ((int'(r_waitCnt) + 1) == WAIT_LIMIT);

  // Next-state and control decode; every control defaults low so each
  // state only lists the signals it actually asserts.
  always_comb begin
    w_nextState  = r_state;
    w_memReq     = 1'b0;
    w_memWe      = 1'b0;
    w_iOrD       = 1'b0;
    w_irWrite    = 1'b0;
    w_pcWrite    = 1'b0;
    w_branch     = 1'b0;
    w_aluOp      = ALU_ADD;
    w_srcA       = SRCA_PC;
    w_srcB       = SRCB_RS2;
    w_regWrite   = 1'b0;
    w_memToReg   = WB_ALUOUT;
    w_retire     = 1'b0;
    w_setIllegal = 1'b0;
    w_setBusErr  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_memReq = 1'b1;
        w_srcB   = SRCB_FOUR;
        if (i_mem_ready) begin
          w_irWrite   = 1'b1;
          w_pcWrite   = 1'b1;
          w_nextState = ST_DECODE;
        end else if (w_timeout) begin
          w_setBusErr = 1'b1;
          w_nextState = ST_TRAP;
        end
      end
      ST_DECODE: begin
        // Precompute the PC-relative target into ALUOut.
        w_srcB = SRCB_IMM;
        case (w_class)
          CLS_R:      w_nextState = ST_EXEC_R;
          CLS_I:      w_nextState = ST_EXEC_I;
          CLS_U:      w_nextState = ST_EXEC_U;
          CLS_BRANCH: w_nextState = ST_BRANCH;
          CLS_MEM:    w_nextState = ST_MEM_ADDR;
          CLS_JAL:    w_nextState = ST_JAL;
          CLS_JALR:   w_nextState = ST_JALR;
          default:    w_nextState = ST_TRAP;
        endcase
        w_setIllegal = w_decIllegal;
      end
      ST_EXEC_R: begin
        w_srcA      = SRCA_RS1;
        w_aluOp     = ALU_FUNCT;
        w_nextState = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        w_srcA      = SRCA_RS1;
        w_srcB      = SRCB_IMM;
        w_aluOp     = ALU_FUNCT;
        w_nextState = ST_WB_ALU;
      end
      ST_EXEC_U: begin
        // opcode[5] separates LUI (zero + imm) from AUIPC (PC + imm).
        w_srcA      = i_opcode[5] ? SRCA_ZERO : SRCA_PC;
        w_srcB      = SRCB_IMM;
        w_nextState = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        w_regWrite  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_BRANCH: begin
        w_srcA      = SRCA_RS1;
        w_aluOp     = ALU_SUB;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        w_srcA      = SRCA_RS1;
        w_srcB      = SRCB_IMM;
        w_nextState = i_opcode[5] ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        w_memReq = 1'b1;
        w_iOrD   = 1'b1;
        if (i_mem_ready) begin
          w_nextState = ST_WB_MEM;
        end else if (w_timeout) begin
          w_setBusErr = 1'b1;
          w_nextState = ST_TRAP;
        end
      end
      ST_WB_MEM: begin
        w_regWrite  = 1'b1;
        w_memToReg  = WB_MDR;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_MEM_WR: begin
        w_memReq = 1'b1;
        w_memWe  = 1'b1;
        w_iOrD   = 1'b1;
        if (i_mem_ready) begin
          w_retire    = 1'b1;
          w_nextState = ST_FETCH;
        end else if (w_timeout) begin
          w_setBusErr = 1'b1;
          w_nextState = ST_TRAP;
        end
      end
      ST_JAL: begin
        w_pcWrite   = 1'b1;
        w_regWrite  = 1'b1;
        w_memToReg  = WB_PC;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_JALR: begin
        w_srcA      = SRCA_RS1;
        w_srcB      = SRCB_IMM;
        w_pcWrite   = 1'b1;
        w_regWrite  = 1'b1;
        w_memToReg  = WB_PC;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_TRAP: w_nextState = ST_TRAP;
      default: w_nextState = ST_FETCH;
    endcase
  end

  // State, stall counter, retired count and sticky flags. The stall counter
  // restarts whenever ready is seen or the FSM is outside a request state,
  // which also clears it on entry to every request state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_FETCH;
      r_waitCnt <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_inReq && !i_mem_ready) r_waitCnt <= r_waitCnt + WCW'(1);
      else                         r_waitCnt <= '0;
      if (w_retire)     r_instret <= r_instret + CNT_W'(1);
      if (w_setIllegal) r_illegal <= 1'b1;
      if (w_setBusErr)  r_busErr  <= 1'b1;
    end
  end

  // All outputs are forced low while reset is held.
  assign o_mem_req    = !i_rst && w_memReq;
  assign o_mem_we     = !i_rst && w_memWe;
  assign o_i_or_d     = !i_rst && w_iOrD;
  assign o_ir_write   = !i_rst && w_irWrite;
  assign o_pc_write   = !i_rst && w_pcWrite;
  assign o_branch     = !i_rst && w_branch;
  assign o_alu_op     = i_rst ? 2'b00 : w_aluOp;
  assign o_alu_src_a  = i_rst ? 2'b00 : w_srcA;
  assign o_alu_src_b  = i_rst ? 2'b00 : w_srcB;
  assign o_reg_write  = !i_rst && w_regWrite;
  assign o_mem_to_reg = i_rst ? 2'b00 : w_memToReg;
  assign o_retire     = !i_rst && w_retire;
  assign o_instret    = i_rst ? '0 : r_instret;
  assign o_illegal    = !i_rst && r_illegal;
  assign o_bus_err    = !i_rst && r_busErr;

endmodule
